// File: rtl/ikaopm_dac_rx_if.sv
// Serial sound stream in, parallel PCM out, for the OPM DAC receiver.
// The master modport is the serialiser/bench side; the slave is the DAC.
interface ikaopm_dac_rx_if;
    logic        i_phi1_NCEN_n;
    logic        i_SO;
    logic        i_SH1;
    logic        i_SH2;
    logic [15:0] o_R_PO;
    logic [15:0] o_L_PO;
    logic        o_R_VALID;
    logic        o_L_VALID;
    logic        o_FMT_ERR;

    modport master (
        output i_phi1_NCEN_n, i_SO, i_SH1, i_SH2,
        input  o_R_PO, o_L_PO, o_R_VALID, o_L_VALID, o_FMT_ERR
    );

    modport slave (
        input  i_phi1_NCEN_n, i_SO, i_SH1, i_SH2,
        output o_R_PO, o_L_PO, o_R_VALID, o_L_VALID, o_FMT_ERR
    );
endinterface

// File: rtl/ikaopm_dac_rx.sv
// YM3012-style serial DAC front end: deserialises SO frames and decodes the
// float word (9b mantissa, sign, 3b exponent) to 16-bit PCM on SH falling edges.
module ikaopm_dac_rx_ch (
    input  logic        i_EMUCLK,
    input  logic        i_MRST_n,
    input  logic        en,
    input  logic        accept,
    input  logic        sh,
    input  logic [15:0] pcm,
    input  logic        zero_exp,
    output logic [15:0] po,
    output logic        vld,
    output logic        err
);
    logic sh_z;
    logic fall;

    // sh_z keeps tracking during fill so the first accepted edge is a real one
    assign fall = en & accept & sh_z & ~sh;

    always_ff @(posedge i_EMUCLK) begin
        if (!i_MRST_n) begin
            sh_z <= 1'b0;
            po   <= '0;
            vld  <= 1'b0;
            err  <= 1'b0;
        end else begin
            vld <= 1'b0;
            if (en)
                sh_z <= sh;
            if (fall) begin
                po  <= pcm;
                vld <= 1'b1;
                if (zero_exp)
                    err <= 1'b1;
            end
        end
    end
endmodule

module ikaopm_dac_rx #(
    parameter int FILL_COUNT = 16
) (
    input  logic               i_EMUCLK,
    input  logic               i_MRST_n,
    ikaopm_dac_rx_if.slave     bus
);
    localparam int NUM_CH = 2;   // lane 0 = right (SH1), lane 1 = left (SH2)

    logic [15:0] sr;
    logic [15:0] sr_next;
    logic [4:0]  fill_cnt;
    logic        en;
    logic        filled;

    logic [2:0]  e;
    logic        s;
    logic [8:0]  m;
    logic [9:0]  v10;
    logic [15:0] v16;
    logic [15:0] pcm;
    logic        zero_exp;
    logic [2:0]  unused_sr_tail;

    logic [NUM_CH-1:0]       sh_in;
    logic [NUM_CH-1:0][15:0] po;
    logic [NUM_CH-1:0]       vld;
    logic [NUM_CH-1:0]       err;

    assign en      = ~bus.i_phi1_NCEN_n;
    assign sr_next = {bus.i_SO, sr[15:1]};
    assign filled  = (fill_cnt == 5'(FILL_COUNT));
    assign sh_in   = {bus.i_SH2, bus.i_SH1};

    always_ff @(posedge i_EMUCLK) begin
        if (!i_MRST_n) begin
            sr       <= '0;
            fill_cnt <= '0;
        end else if (en) begin
            sr <= sr_next;
            if (!filled)
                fill_cnt <= fill_cnt + 5'd1;
        end
    end

    // Decode from the post-shift word: slot 13 lands in sr_next[15]
    assign e              = sr_next[15:13];
    assign s              = sr_next[12];
    assign m              = sr_next[11:3];
    assign unused_sr_tail = sr_next[2:0];
    assign v10            = {~s, m};
    assign v16            = {{6{v10[9]}}, v10};
    assign zero_exp       = (e == 3'd0);
    assign pcm            = zero_exp ? 16'h0000 : (v16 << (e - 3'd1));

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            ikaopm_dac_rx_ch u_ch (
                .i_EMUCLK (i_EMUCLK),
                .i_MRST_n (i_MRST_n),
                .en       (en),
                .accept   (filled),
                .sh       (sh_in[c]),
                .pcm      (pcm),
                .zero_exp (zero_exp),
                .po       (po[c]),
                .vld      (vld[c]),
                .err      (err[c])
            );
        end
    endgenerate

    assign bus.o_R_PO    = po[0];
    assign bus.o_L_PO    = po[1];
    assign bus.o_R_VALID = vld[0];
    assign bus.o_L_VALID = vld[1];
    assign bus.o_FMT_ERR = |err;
endmodule

// File: tb/tb_ikaopm_dac_rx.sv
// Directed bench for ikaopm_dac_rx: frame-level model checked every cycle,
// plus literal expectations from the hand-worked test vectors.
module tb_ikaopm_dac_rx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ikaopm_dac_rx_if bus();
    ikaopm_dac_rx #(.FILL_COUNT(16)) dut (.i_EMUCLK(clk), .i_MRST_n(rst_n), .bus(bus));

    int errs = 0;
    int checks = 0;

    // model state: expected outputs after the next rising edge
    logic [15:0] exp_r = '0, exp_l = '0;
    logic        exp_rv = 1'b0, exp_lv = 1'b0, exp_err = 1'b0;
    bit          q[$];
    int          n_en = 0;
    bit          psh1 = 1'b0, psh2 = 1'b0;
    bit          chk_en = 1'b0;
    int          r_pulses = 0, l_pulses = 0, both_pulses = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_pcm(input int s, input int m, input int e);
        int v;
        if (e == 0) return 16'h0000;
        v = s ? m : m - 512;
        v = v * (1 << (e - 1));
        return v[15:0];
    endfunction

    task automatic step(input logic r, input logic nc, input logic so, input logic s1, input logic s2);
        int s, m, e, base;
        logic [15:0] w;
        @(negedge clk);
        rst_n = r; bus.i_phi1_NCEN_n = nc; bus.i_SO = so; bus.i_SH1 = s1; bus.i_SH2 = s2;
        exp_rv = 1'b0; exp_lv = 1'b0;
        if (!r) begin
            exp_r = '0; exp_l = '0; exp_err = 1'b0;
            q.delete(); n_en = 0; psh1 = 1'b0; psh2 = 1'b0;
        end else if (!nc) begin
            q.push_back(so);
            if (q.size() > 16) void'(q.pop_front());
            if (n_en >= 16 && ((psh1 && !s1) || (psh2 && !s2))) begin
                // last pushed bit is slot 13 of the frame
                base = q.size() - 14;
                m = 0;
                for (int i = 0; i < 9; i++) m += int'(q[base + 1 + i]) << i;
                s = q[base + 10];
                e = q[base + 11] + 2 * q[base + 12] + 4 * q[base + 13];
                w = model_pcm(s, m, e);
                if (psh1 && !s1) begin exp_r = w; exp_rv = 1'b1; end
                if (psh2 && !s2) begin exp_l = w; exp_lv = 1'b1; end
                if (e == 0) exp_err = 1'b1;
            end
            psh1 = s1; psh2 = s2;
            n_en++;
        end
        chk_en = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("R_PO", bus.o_R_PO, exp_r);
            chk("L_PO", bus.o_L_PO, exp_l);
            chk("R_VALID", 16'(bus.o_R_VALID), 16'(exp_rv));
            chk("L_VALID", 16'(bus.o_L_VALID), 16'(exp_lv));
            chk("FMT_ERR", 16'(bus.o_FMT_ERR), 16'(exp_err));
            if (bus.o_R_VALID === 1'b1) r_pulses++;
            if (bus.o_L_VALID === 1'b1) l_pulses++;
            if (bus.o_R_VALID === 1'b1 && bus.o_L_VALID === 1'b1) both_pulses++;
        end
    end

    task automatic do_reset();
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    endtask

    // f1/f2: slot at which SH1/SH2 goes low for one slot (-1 = never);
    // stall: slot before which the enable is withheld for 5 cycles (-1 = none)
    task automatic send_frame(input int s, input int m, input int e,
                              input int f1, input int f2, input int stall);
        logic b, h1, h2;
        for (int slot = 0; slot < 16; slot++) begin
            h1 = (slot == f1) ? 1'b0 : 1'b1;
            h2 = (slot == f2) ? 1'b0 : 1'b1;
            if (slot >= 1 && slot <= 9)        b = 1'(m >> (slot - 1));
            else if (slot == 10)               b = 1'(s);
            else if (slot >= 11 && slot <= 13) b = 1'(e >> (slot - 11));
            else                               b = 1'b0;
            if (slot == stall)
                repeat (5) step(1'b1, 1'b1, 1'($urandom_range(1)), h1, h2);
            step(1'b1, 1'b0, b, h1, h2);
            step(1'b1, 1'b1, 1'b0, h1, h2);
        end
    endtask

    int rp;

    initial begin
        bus.i_phi1_NCEN_n = 1'b1; bus.i_SO = 1'b0; bus.i_SH1 = 1'b1; bus.i_SH2 = 1'b1;

        do_reset();
        chk("rst R_PO", bus.o_R_PO, 16'h0000);
        chk("rst L_PO", bus.o_L_PO, 16'h0000);
        chk("rst FMT_ERR", 16'(bus.o_FMT_ERR), 16'h0000);

        // edge on the 10th enable is inside the fill window
        send_frame(1, 'h1FF, 7, 9, -1, -1);
        chk("fill R_PO", bus.o_R_PO, 16'h0000);
        chk("fill pulses", 16'(r_pulses), 16'd0);

        send_frame(1, 'h1FF, 7, 13, -1, -1);
        chk("max R_PO", bus.o_R_PO, 16'h7FC0);
        chk("max L_PO", bus.o_L_PO, 16'h0000);
        chk("max pulses", 16'(r_pulses), 16'd1);

        send_frame(0, 'h000, 7, -1, 13, -1);
        chk("min L_PO", bus.o_L_PO, 16'h8000);
        send_frame(1, 'h005, 1, -1, 13, -1);
        chk("e1 L_PO", bus.o_L_PO, 16'h0005);

        send_frame(0, 'h1FB, 3, 13, -1, -1);
        chk("neg R_PO", bus.o_R_PO, 16'hFFEC);
        rp = r_pulses;
        send_frame(0, 'h1FB, 3, 13, -1, 7);
        chk("stall R_PO", bus.o_R_PO, 16'hFFEC);
        chk("stall pulses", 16'(r_pulses - rp), 16'd1);

        send_frame(1, 'h100, 0, 13, -1, -1);
        chk("e0 R_PO", bus.o_R_PO, 16'h0000);
        chk("e0 FMT_ERR", 16'(bus.o_FMT_ERR), 16'h0001);
        send_frame(1, 'h1FF, 7, 13, -1, -1);
        send_frame(0, 'h1FB, 3, 13, -1, -1);
        send_frame(1, 'h005, 1, 13, -1, -1);
        chk("sticky R_PO", bus.o_R_PO, 16'h0005);
        chk("sticky FMT_ERR", 16'(bus.o_FMT_ERR), 16'h0001);

        send_frame(1, 'h0AA, 2, 13, 13, -1);
        chk("both R_PO", bus.o_R_PO, 16'h0154);
        chk("both L_PO", bus.o_L_PO, 16'h0154);
        chk("both same-cycle", 16'(both_pulses), 16'd1);

        do_reset();
        chk("rst2 FMT_ERR", 16'(bus.o_FMT_ERR), 16'h0000);
        chk("rst2 L_PO", bus.o_L_PO, 16'h0000);
        // slot 13 of the first frame is only the 14th enable: still filling
        send_frame(0, 'h1FB, 3, 13, -1, -1);
        chk("refill R_PO", bus.o_R_PO, 16'h0000);
        send_frame(0, 'h1FB, 3, 13, -1, -1);
        chk("post-fill R_PO", bus.o_R_PO, 16'hFFEC);

        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
